// File: rtl/ram2video_pkg.sv
// Shared configuration for the line-buffer reader: ring geometry, 640x480p timing,
// raster counter type and the sequencing state enum.
package ram2video_pkg;

  // Ring buffer geometry, shared with the writer side.
  localparam int unsigned DEF_RAM_ADDRESS_BITS   = 14;
  localparam int unsigned DEF_BUFFER_LINE_LENGTH = 640;
  localparam int unsigned DEF_RAM_NUMWORDS       = 10240;
  localparam int unsigned DEF_RD_LATENCY         = 2;

  // 640x480p timing.
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;

  localparam int unsigned COUNTER_BITS = 12;
  typedef logic [COUNTER_BITS-1:0] cnt_t;

  typedef enum logic [0:0] {
    StWait,
    StRun
  } state_e;

  // True when lo <= pos < hi.
  function automatic logic in_window(cnt_t pos, cnt_t lo, cnt_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/sync_pulse_detect.sv
// Two-flop synchroniser followed by a rising-edge detector for slow cross-domain triggers.
module sync_pulse_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] fill_q;

  // Synchronise, keep the previous synchronised level, and track pipeline fill after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Edges are only reported once prev_q holds a real sample, so a level held
  // through reset release is not mistaken for a fresh edge.
  assign pulse = sync_q[1] & ~prev_q & fill_q[2];

endmodule

// File: rtl/ram2video.sv
// Line-buffer reader: waits for the writer trigger, then runs fixed raster timing,
// reads the ring buffer in write order and drives RGB/sync/DE aligned to RAM latency.
module ram2video
  import ram2video_pkg::*;
#(
  parameter int unsigned H_ACTIVE           = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT            = DEF_H_FRONT,
  parameter int unsigned H_SYNC             = DEF_H_SYNC,
  parameter int unsigned H_BACK             = DEF_H_BACK,
  parameter int unsigned V_ACTIVE           = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT            = DEF_V_FRONT,
  parameter int unsigned V_SYNC             = DEF_V_SYNC,
  parameter int unsigned V_BACK             = DEF_V_BACK,
  parameter bit          SYNC_POL           = DEF_SYNC_POL,
  parameter int unsigned RAM_ADDRESS_BITS   = DEF_RAM_ADDRESS_BITS,
  parameter int unsigned BUFFER_LINE_LENGTH = DEF_BUFFER_LINE_LENGTH,
  parameter int unsigned RAM_NUMWORDS       = DEF_RAM_NUMWORDS,
  parameter int unsigned RD_LATENCY         = DEF_RD_LATENCY
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        starttrigger,
  input  logic [23:0]                 rddata,
  output logic [RAM_ADDRESS_BITS-1:0] rdaddr,
  output logic                        rdclock,
  output logic [7:0]                  R,
  output logic [7:0]                  G,
  output logic [7:0]                  B,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        DE,
  output logic [11:0]                 counterX,
  output logic [11:0]                 counterY,
  output logic                        running
);

  typedef logic [RAM_ADDRESS_BITS-1:0] addr_t;

  // One stage for the rdaddr register plus the RAM read latency.
  localparam int unsigned PIPE_LEN = RD_LATENCY + 1;

  localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
  localparam cnt_t H_LAST_C  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t HS_BEG_C  = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t HS_END_C  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
  localparam cnt_t V_LAST_C  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t VS_BEG_C  = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t VS_END_C  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam addr_t LINE_LEN_C = addr_t'(BUFFER_LINE_LENGTH);
  localparam addr_t LB_LIMIT_C = addr_t'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);

  state_e state_q, state_d;
  cnt_t   cnt_x_q, cnt_x_d;
  cnt_t   cnt_y_q, cnt_y_d;
  addr_t  line_base_q, line_base_d;
  addr_t  rdaddr_q, rdaddr_d;

  logic [PIPE_LEN-1:0] de_pipe_q;
  logic [PIPE_LEN-1:0] hs_pipe_q;
  logic [PIPE_LEN-1:0] vs_pipe_q;

  logic trig_pulse;
  logic run;
  logic de_raw;
  logic hs_raw;
  logic vs_raw;

  sync_pulse_detect u_trig_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (starttrigger),
    .pulse    (trig_pulse)
  );

  assign run = (state_q == StRun);

  // Sequencing: a single trigger starts the raster, only reset stops it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (trig_pulse) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StWait;
    endcase
  end

  // Raster counters and ring line base; held at zero while waiting.
  always_comb begin
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    line_base_d = line_base_q;
    if (!run) begin
      cnt_x_d     = '0;
      cnt_y_d     = '0;
      line_base_d = '0;
    end else if (cnt_x_q == H_LAST_C) begin
      cnt_x_d = '0;
      cnt_y_d = (cnt_y_q == V_LAST_C) ? '0 : cnt_y_q + 1'b1;
      // Advance through the ring exactly as the writer fills it.
      if (cnt_y_q == V_LAST_C) begin
        line_base_d = '0;
      end else if (cnt_y_q < V_ACT_C) begin
        line_base_d = (line_base_q < LB_LIMIT_C) ? line_base_q + LINE_LEN_C : '0;
      end
    end else begin
      cnt_x_d = cnt_x_q + 1'b1;
    end
  end

  // Undelayed timing and read address; rdaddr holds outside the active region.
  always_comb begin
    de_raw   = run && (cnt_x_q < H_ACT_C) && (cnt_y_q < V_ACT_C);
    hs_raw   = run && in_window(cnt_x_q, HS_BEG_C, HS_END_C);
    vs_raw   = run && in_window(cnt_y_q, VS_BEG_C, VS_END_C);
    rdaddr_d = de_raw ? line_base_q + addr_t'(cnt_x_q) : rdaddr_q;
  end

  // State, counters, address register and timing delay line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWait;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      line_base_q <= '0;
      rdaddr_q    <= '0;
      de_pipe_q   <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      line_base_q <= line_base_d;
      rdaddr_q    <= rdaddr_d;
      de_pipe_q   <= {de_pipe_q[PIPE_LEN-2:0], de_raw};
      hs_pipe_q   <= {hs_pipe_q[PIPE_LEN-2:0], hs_raw};
      vs_pipe_q   <= {vs_pipe_q[PIPE_LEN-2:0], vs_raw};
    end
  end

  // Output register: pixel data gated by delayed DE, syncs at the configured polarity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      DE    <= 1'b0;
      R     <= 8'd0;
      G     <= 8'd0;
      B     <= 8'd0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else begin
      DE    <= de_pipe_q[PIPE_LEN-1];
      R     <= de_pipe_q[PIPE_LEN-1] ? rddata[23:16] : 8'd0;
      G     <= de_pipe_q[PIPE_LEN-1] ? rddata[15:8]  : 8'd0;
      B     <= de_pipe_q[PIPE_LEN-1] ? rddata[7:0]   : 8'd0;
      hsync <= hs_pipe_q[PIPE_LEN-1] ? SYNC_POL : ~SYNC_POL;
      vsync <= vs_pipe_q[PIPE_LEN-1] ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign rdaddr   = rdaddr_q;
  assign rdclock  = clock;
  assign counterX = cnt_x_q;
  assign counterY = cnt_y_q;
  assign running  = run;

endmodule

// File: doc/ram2video.md
Name: ram2video

Overview:
- Downstream consumer of the line-buffer RAM that video2ram fills.
- Waits for the writer's start trigger, then generates fixed 640x480p output timing in the output pixel clock domain.
- Reads pixels back from the ring buffer in write order and drives RGB, sync and data-enable, aligned to the RAM read latency, toward the HDMI transmitter.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_POL, 0, sync active level (0 = active-low)
- RAM_ADDRESS_BITS, 14, read address width; equals the writer's `RAM_ADDRESS_BITS
- BUFFER_LINE_LENGTH, 640, RAM words per buffered line
- RAM_NUMWORDS, 10240, ring size in words
- RD_LATENCY, 2, RAM read latency in clocks (1..3)

Ports:
- clock  in  1  output pixel clock; also RAM read clock
- reset_n  in  1  reset, asynchronous and active-low
- starttrigger  in  1  writer trigger from the input clock domain; guaranteed ≥2 clock periods wide
- rddata  in  24  RAM read data {R,G,B}
- rdaddr  out  RAM_ADDRESS_BITS  RAM read address
- rdclock  out  1  equals clock
- R, G, B  out  8 each  pixel data
- hsync, vsync  out  1 each  syncs, level per SYNC_POL
- DE  out  1  data enable
- counterX, counterY  out  12 each  undelayed raster position
- running  out  1  high once timing has started

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Trigger synchroniser: starttrigger passes through a 2-FF synchroniser, then a rising-edge detector produces trig_pulse.
- State machine, WAIT:
  - Counters are held at 0 and running = 0.
  - Outputs sit idle: DE = 0, RGB = 0, syncs inactive.
  - On trig_pulse, go to RUN with counterX = counterY = 0 and line_base = 0 on the next clock.
- State machine, RUN:
  - Free-running raster; further trig_pulses are ignored.
  - Leaves RUN only via reset.
- Counters: counterX increments each clock and wraps H_TOTAL-1 to 0. counterY increments on the X wrap and wraps V_TOTAL-1 to 0.
- line_base update, at counterX = H_TOTAL-1:
  - If counterY = V_TOTAL-1, line_base becomes 0.
  - Else if counterY < V_ACTIVE and line_base < RAM_NUMWORDS-BUFFER_LINE_LENGTH, line_base += BUFFER_LINE_LENGTH.
  - Else if counterY < V_ACTIVE, line_base wraps to 0.
  - Otherwise line_base is held.
  - This matches the writer's ring order exactly.
- Read address: when counterX < H_ACTIVE and counterY < V_ACTIVE, rdaddr <= line_base + counterX (registered); otherwise rdaddr holds its value.
- Raw timing (undelayed):
  - de_raw = active region.
  - hs_raw asserted for H_ACTIVE+H_FRONT ≤ counterX < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw asserted for V_ACTIVE+V_FRONT ≤ counterY < V_ACTIVE+V_FRONT+V_SYNC.
- Alignment: de_raw, hs_raw and vs_raw pass through a shift pipeline of RD_LATENCY+1 stages (1 for the rdaddr register, RD_LATENCY for the RAM), then one output register.
  - Total latency from counter position to pins = RD_LATENCY+2 clocks.
- Output register: R,G,B = rddata when delayed DE = 1, else 0. hsync/vsync = SYNC_POL when the delayed raw sync is asserted, else ~SYNC_POL.
- Reset (async, any state):
  - State = WAIT; counters, line_base, rdaddr and all delay stages = 0.
  - DE = 0, RGB = 0, hsync = vsync = ~SYNC_POL, running = 0.
  - Synchroniser flops cleared.
- Reset mid-frame: the raster stops immediately and the next trigger restarts it from (0,0).
- Trigger held high across reset release: no start until a fresh rising edge after release.
- rdaddr never exceeds RAM_NUMWORDS-1, including at the ring wrap.

Decomposition:
- Shared package/include (extends config.inc): RAM_ADDRESS_BITS, BUFFER_LINE_LENGTH, RAM_NUMWORDS, the 640x480 timing constants, and the state enum {WAIT, RUN}.
- One natural sub-module, sync_pulse_detect: 2-FF synchroniser plus rising-edge detect with async active-low reset; reusable for other cross-domain triggers.

Test Plan:
- Reset, then 100 clocks with starttrigger = 0 -> running = 0, DE = 0, RGB = 0, hsync = vsync = 1, rdaddr = 0 throughout.
- starttrigger high for 3 clocks -> running rises; counterX = 0, counterY = 0 on the clock after trig_pulse. First rdaddr = 0; rdaddr = 639 at counterX = 639 of line 0, then line 1 starts at 640. First DE = 1 appears RD_LATENCY+2 = 4 clocks after counterX = 0.
- Model RAM returns word = address -> pixel at output column n of line k equals (k*640 + n) mod 10240. Lines 0..15 are followed by line 16 at base 0 (wrap); the last active line, 479, uses base (479 mod 16)*640 = 9600.
- Full frame -> exactly 800 clocks per line and 525 lines. hsync low for clocks 656..751 of each line; vsync low on lines 490..491; DE count = 307200 per frame.
- Second starttrigger pulse mid-frame (counterY = 200) -> counters continue unperturbed, no restart.
- reset_n asserted asynchronously at counterY = 300 with starttrigger held high -> outputs go to reset values immediately. After release there is no restart until starttrigger falls and rises again.
